// File: rtl/pipe_datapath_pkg.sv
// Shared opcode map, instruction field positions and reset/squash defaults
// for the three-stage pipelined datapath.
package pipe_datapath_pkg;

  typedef enum logic [3:0] {
    OP_MV   = 4'd0,
    OP_ADD  = 4'd1,
    OP_SUB  = 4'd2,
    OP_CMP  = 4'd3,
    OP_LD   = 4'd4,
    OP_ST   = 4'd5,
    OP_MVHI = 4'd6,
    OP_NOP  = 4'd7,
    OP_J    = 4'd8,
    OP_JZ   = 4'd9,
    OP_JN   = 4'd10,
    OP_CALL = 4'd12
  } opcode_e;

  localparam int OP_MSB    = 3;
  localparam int OP_LSB    = 0;
  localparam int IMM_BIT   = 4;
  localparam int RX_MSB    = 7;
  localparam int RX_LSB    = 5;
  localparam int RY_MSB    = 10;
  localparam int RY_LSB    = 8;
  localparam int IMM8_LSB  = 8;
  localparam int IMM11_LSB = 5;

  localparam logic [15:0] NOP_IR_DEF = 16'h0007;
  localparam logic [2:0]  LINK_REG   = 3'd7;

  function automatic logic writes_reg(input logic [3:0] op);
    return (op == OP_MV) || (op == OP_ADD) || (op == OP_SUB) ||
           (op == OP_MVHI) || (op == OP_LD) || (op == OP_CALL);
  endfunction

endpackage

// File: rtl/pipe_datapath_p_regfile.sv
// Eight-entry register file: two combinational read ports with write-through
// of the same-cycle write, one write port, and a flat image for observation.
module regfile_p #(
  parameter int DATA_W = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   we,
  input  logic [2:0]             waddr,
  input  logic [DATA_W-1:0]      wdata,
  input  logic [2:0]             raddr_a,
  input  logic [2:0]             raddr_b,
  output logic [DATA_W-1:0]      rdata_a,
  output logic [DATA_W-1:0]      rdata_b,
  output logic [7:0][DATA_W-1:0] regs_image
);

  logic [DATA_W-1:0] regs_reg [8];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 8; i++) regs_reg[i] <= '0;
    end else if (we) begin
      regs_reg[waddr] <= wdata;
    end
  end

  assign rdata_a = (we && (waddr == raddr_a)) ? wdata : regs_reg[raddr_a];
  assign rdata_b = (we && (waddr == raddr_b)) ? wdata : regs_reg[raddr_b];

  generate
    for (genvar gi = 0; gi < 8; gi++) begin : g_image
      assign regs_image[gi] = regs_reg[gi];
    end
  endgenerate

endmodule

// File: rtl/pipe_datapath_p.sv
// Three-stage (F, D/X, W) datapath with sync instruction fetch, branch
// resolution in X with a single squash bubble, and optional W->X bypass.
module pipe_datapath_p
  import pipe_datapath_pkg::*;
#(
  parameter int          DATA_W = 16,
  parameter int          FWD_EN = 1,
  parameter logic [15:0] NOP_IR = NOP_IR_DEF
) (
  input  logic                   clk,
  input  logic                   reset,
  output logic [DATA_W-1:0]      o_pc_addr,
  input  logic [15:0]            i_pc_rddata,
  output logic [DATA_W-1:0]      o_ldst_addr,
  output logic [DATA_W-1:0]      o_ldst_wrdata,
  output logic                   o_ldst_rd,
  output logic                   o_ldst_wr,
  input  logic [DATA_W-1:0]      i_ldst_rddata,
  input  logic                   i_stall,
  output logic                   o_n,
  output logic                   o_z,
  output logic [7:0][DATA_W-1:0] o_tb_regs
);

  localparam logic [DATA_W-1:0] PC_STEP = DATA_W'(2);

  logic [DATA_W-1:0] pc_reg, pc_d_reg, pc_x_reg;
  logic [15:0]       ir_d_reg, ir_x_reg;
  logic              d_held_reg, w_held_reg;
  logic [DATA_W-1:0] a_x_reg, b_x_reg, res_w_reg;
  logic [3:0]        op_w_reg;
  logic [2:0]        rx_w_reg;
  logic              n_reg, z_reg;

  logic [15:0]       ir_d;
  logic [DATA_W-1:0] rd_a, rd_b;
  logic              w_we, rf_we;
  logic [2:0]        w_dst;
  logic [DATA_W-1:0] w_data;

  // The sync fetch memory keeps reading the held address during a stall, so
  // the word already delivered to D is captured and replayed afterwards.
  assign ir_d = d_held_reg ? ir_d_reg : i_pc_rddata;

  assign w_we   = writes_reg(op_w_reg);
  assign rf_we  = w_we && !i_stall;
  assign w_dst  = (op_w_reg == OP_CALL) ? LINK_REG : rx_w_reg;
  assign w_data = ((op_w_reg == OP_LD) && !w_held_reg) ? i_ldst_rddata : res_w_reg;

  regfile_p #(.DATA_W(DATA_W)) u_regfile (
    .clk        (clk),
    .reset      (reset),
    .we         (rf_we),
    .waddr      (w_dst),
    .wdata      (w_data),
    .raddr_a    (ir_d[RX_MSB:RX_LSB]),
    .raddr_b    (ir_d[RY_MSB:RY_LSB]),
    .rdata_a    (rd_a),
    .rdata_b    (rd_b),
    .regs_image (o_tb_regs)
  );

  logic [3:0]        op_x;
  logic [2:0]        rx_x, ry_x;
  logic [DATA_W-1:0] imm8_x, imm11_x, rx_val, ry_val, opb, alu_res, target;
  logic              set_flags, br_cond, taken;

  assign op_x    = ir_x_reg[OP_MSB:OP_LSB];
  assign rx_x    = ir_x_reg[RX_MSB:RX_LSB];
  assign ry_x    = ir_x_reg[RY_MSB:RY_LSB];
  assign imm8_x  = {{(DATA_W-8){ir_x_reg[15]}}, ir_x_reg[15:IMM8_LSB]};
  assign imm11_x = {{(DATA_W-11){ir_x_reg[15]}}, ir_x_reg[15:IMM11_LSB]};

  assign rx_val = ((FWD_EN != 0) && w_we && (w_dst == rx_x)) ? w_data : a_x_reg;
  assign ry_val = ((FWD_EN != 0) && w_we && (w_dst == ry_x)) ? w_data : b_x_reg;
  assign opb    = ir_x_reg[IMM_BIT] ? imm8_x : ry_val;
  assign target = ir_x_reg[IMM_BIT] ? (pc_x_reg + {imm11_x[DATA_W-2:0], 1'b0}) : rx_val;

  always_comb begin
    alu_res   = '0;
    set_flags = 1'b0;
    br_cond   = 1'b0;
    case (op_x)
      OP_MV:         alu_res = opb;
      OP_ADD:        begin alu_res = rx_val + opb; set_flags = 1'b1; end
      OP_SUB,
      OP_CMP:        begin alu_res = rx_val - opb; set_flags = 1'b1; end
      OP_MVHI:       alu_res = (imm8_x << 8) | {{(DATA_W-8){1'b0}}, rx_val[7:0]};
      OP_J:          br_cond = 1'b1;
      OP_JZ:         br_cond = z_reg;
      OP_JN:         br_cond = n_reg;
      OP_CALL:       begin br_cond = 1'b1; alu_res = pc_x_reg + PC_STEP; end
      default:       ;
    endcase
  end

  assign taken         = br_cond && !i_stall && !reset;
  assign o_pc_addr     = taken ? target : pc_reg;
  assign o_ldst_addr   = ry_val;
  assign o_ldst_wrdata = rx_val;
  assign o_ldst_rd     = (op_x == OP_LD) && !i_stall && !reset;
  assign o_ldst_wr     = (op_x == OP_ST) && !i_stall && !reset;
  assign o_n           = n_reg;
  assign o_z           = z_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_reg     <= '0;
      pc_d_reg   <= '0;
      pc_x_reg   <= '0;
      ir_d_reg   <= NOP_IR;
      d_held_reg <= 1'b1;
      ir_x_reg   <= NOP_IR;
      a_x_reg    <= '0;
      b_x_reg    <= '0;
      op_w_reg   <= NOP_IR[OP_MSB:OP_LSB];
      rx_w_reg   <= NOP_IR[RX_MSB:RX_LSB];
      res_w_reg  <= '0;
      w_held_reg <= 1'b0;
      n_reg      <= 1'b0;
      z_reg      <= 1'b0;
    end else if (i_stall) begin
      if (!d_held_reg) begin
        ir_d_reg   <= i_pc_rddata;
        d_held_reg <= 1'b1;
      end
      // Load data is only valid for one cycle; keep it for the resumed write.
      if (!w_held_reg) begin
        res_w_reg  <= w_data;
        w_held_reg <= 1'b1;
      end
    end else begin
      pc_reg     <= o_pc_addr + PC_STEP;
      pc_d_reg   <= o_pc_addr;
      d_held_reg <= 1'b0;
      ir_x_reg   <= taken ? NOP_IR : ir_d;
      pc_x_reg   <= pc_d_reg;
      a_x_reg    <= rd_a;
      b_x_reg    <= rd_b;
      op_w_reg   <= op_x;
      rx_w_reg   <= rx_x;
      res_w_reg  <= alu_res;
      w_held_reg <= 1'b0;
      if (set_flags) begin
        n_reg <= alu_res[DATA_W-1];
        z_reg <= (alu_res == '0);
      end
    end
  end

endmodule

// File: tb/tb_pipe_datapath_p.sv
// Directed bench for pipe_datapath_p: 16-bit and 32-bit instances run the same
// program image, each with its own registered instruction and data memories.
module tb_pipe_datapath_p;

  logic clk, reset, stall;

  logic [15:0]       prog [128];

  logic [15:0]       pc16, ldaddr16, wdata16, ldrd16;
  logic [15:0]       ir16;
  logic              rd16, wr16, n16, z16;
  logic [7:0][15:0]  regs16;
  logic [15:0]       dmem16 [256];

  logic [31:0]       pc32, ldaddr32, wdata32, ldrd32;
  logic [15:0]       ir32;
  logic              rd32, wr32, n32, z32;
  logic [7:0][31:0]  regs32;
  logic [31:0]       dmem32 [256];

  int checks = 0;
  int failures = 0;

  pipe_datapath_p #(.DATA_W(16), .FWD_EN(1)) u_dut16 (
    .clk(clk), .reset(reset), .o_pc_addr(pc16), .i_pc_rddata(ir16),
    .o_ldst_addr(ldaddr16), .o_ldst_wrdata(wdata16), .o_ldst_rd(rd16), .o_ldst_wr(wr16),
    .i_ldst_rddata(ldrd16), .i_stall(stall), .o_n(n16), .o_z(z16), .o_tb_regs(regs16)
  );

  pipe_datapath_p #(.DATA_W(32), .FWD_EN(1)) u_dut32 (
    .clk(clk), .reset(reset), .o_pc_addr(pc32), .i_pc_rddata(ir32),
    .o_ldst_addr(ldaddr32), .o_ldst_wrdata(wdata32), .o_ldst_rd(rd32), .o_ldst_wr(wr32),
    .i_ldst_rddata(ldrd32), .i_stall(stall), .o_n(n32), .o_z(z32), .o_tb_regs(regs32)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    ir16 <= prog[pc16[7:1]];
    ir32 <= prog[pc32[7:1]];
    if (wr16) dmem16[ldaddr16[7:0]] <= wdata16;
    if (rd16) ldrd16 <= dmem16[ldaddr16[7:0]];
    if (wr32) dmem32[ldaddr32[7:0]] <= wdata32;
    if (rd32) ldrd32 <= dmem32[ldaddr32[7:0]];
  end

  task automatic clear_prog();
    for (int i = 0; i < 128; i++) prog[i] = 16'h0007;
  endtask

  // Leaves the bench at the falling edge of the first post-reset cycle.
  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    stall = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic test_reset();
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    checks++; if (pc16 !== 16'h0000) begin failures++; $display("FAIL reset_pc16: got %h want 0000", pc16); end
    checks++; if (pc32 !== 32'h0) begin failures++; $display("FAIL reset_pc32: got %h want 0", pc32); end
    checks++; if (regs16 !== '0) begin failures++; $display("FAIL reset_regs16: got %h want 0", regs16); end
    checks++; if ({n16, z16} !== 2'b00) begin failures++; $display("FAIL reset_flags: got n=%b z=%b want 0 0", n16, z16); end
    checks++; if ({rd16, wr16} !== 2'b00) begin failures++; $display("FAIL reset_ldst: got rd=%b wr=%b want 0 0", rd16, wr16); end
    reset = 1'b0;
    $display("test_reset done");
  endtask

  task automatic test_fwd_add();
    clear_prog();
    prog[0] = 16'h0530; // mvi r1,5
    prog[1] = 16'h0350; // mvi r2,3
    prog[2] = 16'h0221; // add r1,r2
    do_reset();
    step(8);
    checks++; if (regs16[1] !== 16'd8) begin failures++; $display("FAIL fwd_add_r1: got %h want 0008", regs16[1]); end
    checks++; if (regs16[2] !== 16'd3) begin failures++; $display("FAIL fwd_add_r2: got %h want 0003", regs16[2]); end
    checks++; if ({n16, z16} !== 2'b00) begin failures++; $display("FAIL fwd_add_flags: got n=%b z=%b want 0 0", n16, z16); end
    $display("test_fwd_add done");
  endtask

  task automatic test_flags();
    clear_prog();
    prog[0] = 16'h0330; // mvi r1,3
    prog[1] = 16'h0533; // cmp r1,5
    do_reset();
    step(6);
    checks++; if (regs16[1] !== 16'd3) begin failures++; $display("FAIL cmp_r1: got %h want 0003", regs16[1]); end
    checks++; if ({n16, z16} !== 2'b10) begin failures++; $display("FAIL cmp_flags: got n=%b z=%b want 1 0", n16, z16); end
    $display("test_flags done");
  endtask

  task automatic test_branch();
    clear_prog();
    prog[0] = 16'h0130; // mvi r1,1
    prog[1] = 16'h0132; // sub r1,1
    prog[2] = 16'h0059; // jz pc+4
    prog[3] = 16'h1170; // mvi r3,0x11 (squashed)
    prog[4] = 16'h2290; // mvi r4,0x22 (target)
    do_reset();
    step(3);
    checks++; if (pc16 !== 16'h0006) begin failures++; $display("FAIL br_pre: got %h want 0006", pc16); end
    step(1);
    checks++; if (pc16 !== 16'h0008) begin failures++; $display("FAIL br_target: got %h want 0008", pc16); end
    step(1);
    checks++; if (pc16 !== 16'h000A) begin failures++; $display("FAIL br_next: got %h want 000a", pc16); end
    step(5);
    checks++; if (regs16[3] !== 16'h0000) begin failures++; $display("FAIL br_squash_r3: got %h want 0000", regs16[3]); end
    checks++; if (regs16[4] !== 16'h0022) begin failures++; $display("FAIL br_target_r4: got %h want 0022", regs16[4]); end
    checks++; if (regs16[1] !== 16'h0000) begin failures++; $display("FAIL br_r1: got %h want 0000", regs16[1]); end
    checks++; if (z16 !== 1'b1) begin failures++; $display("FAIL br_z: got %b want 1", z16); end
    $display("test_branch done");
  endtask

  task automatic test_ldst();
    clear_prog();
    prog[0] = 16'h5A70; // mvi r3,0x5a
    prog[1] = 16'h2090; // mvi r4,0x20
    prog[2] = 16'h0465; // st r3,[r4]
    prog[3] = 16'h04A4; // ld r5,[r4]
    do_reset();
    step(3);
    checks++; if (wr16 !== 1'b0) begin failures++; $display("FAIL st_early: got wr=%b want 0", wr16); end
    step(1);
    checks++; if ({wr16, rd16} !== 2'b10) begin failures++; $display("FAIL st_strobe: got wr=%b rd=%b want 1 0", wr16, rd16); end
    checks++; if (ldaddr16 !== 16'h0020) begin failures++; $display("FAIL st_addr: got %h want 0020", ldaddr16); end
    checks++; if (wdata16 !== 16'h005A) begin failures++; $display("FAIL st_data: got %h want 005a", wdata16); end
    step(1);
    checks++; if ({wr16, rd16} !== 2'b01) begin failures++; $display("FAIL ld_strobe: got wr=%b rd=%b want 0 1", wr16, rd16); end
    checks++; if (ldaddr16 !== 16'h0020) begin failures++; $display("FAIL ld_addr: got %h want 0020", ldaddr16); end
    step(1);
    checks++; if (rd16 !== 1'b0) begin failures++; $display("FAIL ld_once: got rd=%b want 0", rd16); end
    step(2);
    checks++; if (regs16[5] !== 16'h005A) begin failures++; $display("FAIL ld_r5: got %h want 005a", regs16[5]); end
    $display("test_ldst done");
  endtask

  task automatic test_call();
    clear_prog();
    prog[0]  = 16'h40D0; // mvi r6,0x40
    prog[8]  = 16'h00CC; // call r6 at 0x10
    prog[9]  = 16'h1170; // mvi r3,0x11 at 0x12 (squashed)
    prog[32] = 16'h7750; // mvi r2,0x77 at 0x40
    do_reset();
    step(10);
    checks++; if (pc16 !== 16'h0040) begin failures++; $display("FAIL call_target: got %h want 0040", pc16); end
    step(1);
    checks++; if (pc16 !== 16'h0042) begin failures++; $display("FAIL call_next: got %h want 0042", pc16); end
    step(4);
    checks++; if (regs16[7] !== 16'h0012) begin failures++; $display("FAIL call_r7: got %h want 0012", regs16[7]); end
    checks++; if (regs16[2] !== 16'h0077) begin failures++; $display("FAIL call_r2: got %h want 0077", regs16[2]); end
    checks++; if (regs16[3] !== 16'h0000) begin failures++; $display("FAIL call_squash: got %h want 0000", regs16[3]); end
    $display("test_call done");
  endtask

  task automatic load_add_seq();
    clear_prog();
    prog[0] = 16'h0530; // mvi r1,5
    prog[1] = 16'h0350; // mvi r2,3
    prog[2] = 16'h0221; // add r1,r2
    prog[3] = 16'h0221; // add r1,r2
    prog[4] = 16'h0141; // add r2,r1
  endtask

  task automatic test_back_to_back();
    load_add_seq();
    do_reset();
    step(10);
    checks++; if (regs16[1] !== 16'd11) begin failures++; $display("FAIL b2b_r1: got %h want 000b", regs16[1]); end
    checks++; if (regs16[2] !== 16'd14) begin failures++; $display("FAIL b2b_r2: got %h want 000e", regs16[2]); end
    $display("test_back_to_back done");
  endtask

  task automatic test_stall();
    load_add_seq();
    do_reset();
    step(3);
    stall = 1'b1;
    step(1);
    checks++; if (pc16 !== 16'h0006) begin failures++; $display("FAIL stall_pc1: got %h want 0006", pc16); end
    checks++; if (regs16[1] !== 16'h0000) begin failures++; $display("FAIL stall_r1: got %h want 0000", regs16[1]); end
    step(1);
    checks++; if (pc16 !== 16'h0006) begin failures++; $display("FAIL stall_pc2: got %h want 0006", pc16); end
    checks++; if ({rd16, wr16} !== 2'b00) begin failures++; $display("FAIL stall_ldst: got rd=%b wr=%b want 0 0", rd16, wr16); end
    step(1);
    stall = 1'b0;
    step(10);
    checks++; if (regs16[1] !== 16'd11) begin failures++; $display("FAIL stall_r1_final: got %h want 000b", regs16[1]); end
    checks++; if (regs16[2] !== 16'd14) begin failures++; $display("FAIL stall_r2_final: got %h want 000e", regs16[2]); end
    checks++; if ({n16, z16} !== 2'b00) begin failures++; $display("FAIL stall_flags: got n=%b z=%b want 0 0", n16, z16); end
    $display("test_stall done");
  endtask

  task automatic test_w32();
    clear_prog();
    prog[0] = 16'hFF30; // mvi r1,-1
    prog[1] = 16'h0131; // add r1,1
    prog[2] = 16'h5550; // mvi r2,0x55
    prog[3] = 16'h6670; // mvi r3,0x66
    prog[4] = 16'h0198; // j pc+0x18 -> 0x20
    do_reset();
    step(4);
    checks++; if (regs32[1] !== 32'hFFFF_FFFF) begin failures++; $display("FAIL w32_mvi: got %h want ffffffff", regs32[1]); end
    step(1);
    checks++; if (regs32[1] !== 32'h0) begin failures++; $display("FAIL w32_add: got %h want 00000000", regs32[1]); end
    checks++; if ({n32, z32} !== 2'b01) begin failures++; $display("FAIL w32_flags: got n=%b z=%b want 0 1", n32, z32); end
    step(1);
    checks++; if (pc32 !== 32'h20) begin failures++; $display("FAIL w32_jump: got %h want 00000020", pc32); end
    checks++; if (regs32[2] !== 32'h55) begin failures++; $display("FAIL w32_r2: got %h want 00000055", regs32[2]); end
    reset = 1'b1;
    step(1);
    checks++; if (pc32 !== 32'h0) begin failures++; $display("FAIL w32_rst_pc: got %h want 0", pc32); end
    checks++; if (regs32 !== '0) begin failures++; $display("FAIL w32_rst_regs: got %h want 0", regs32); end
    checks++; if (z32 !== 1'b0) begin failures++; $display("FAIL w32_rst_z: got %b want 0", z32); end
    reset = 1'b0;
    checks++; if (pc32 !== 32'h0) begin failures++; $display("FAIL w32_first_fetch: got %h want 0", pc32); end
    step(1);
    checks++; if (pc32 !== 32'h2) begin failures++; $display("FAIL w32_second_fetch: got %h want 2", pc32); end
    $display("test_w32 done");
  endtask

  initial begin
    reset = 1'b1;
    stall = 1'b0;
    clear_prog();
    for (int i = 0; i < 256; i++) begin
      dmem16[i] = 16'h0;
      dmem32[i] = 32'h0;
    end
    test_reset();
    test_fwd_add();
    test_flags();
    test_branch();
    test_ldst();
    test_call();
    test_back_to_back();
    test_stall();
    test_w32();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pipe_datapath_p.md
PIPE_DATAPATH_P -- requirements
Module: pipe_datapath_p

Interface
REQ-001 SHALL have parameter DATA_W, default 16, meaning register/ALU/PC/data width (legal 16..32).
REQ-002 SHALL have parameter FWD_EN, default 1, meaning enable internal W->X forwarding (0: bench-visible hazards, no bypass).
REQ-003 SHALL have parameter NOP_IR, default 16'h0007, meaning instruction inserted on squash.
REQ-004 SHALL have ports: clk  in  1  clock; one clock; reset  in  1  synchronous, active-high.
REQ-005 SHALL have ports: o_pc_addr  out  DATA_W  fetch address; i_pc_rddata  in  16  instruction, valid one cycle after address.
REQ-006 SHALL have ports: o_ldst_addr  out  DATA_W; o_ldst_wrdata  out  DATA_W; o_ldst_rd  out  1; o_ldst_wr  out  1; i_ldst_rddata  in  DATA_W, valid one cycle after o_ldst_rd.
REQ-007 SHALL have ports: i_stall  in  1  freeze all pipeline state; o_n  out  1; o_z  out  1; o_tb_regs  out  8xDATA_W  register file image.

Function
REQ-010 SHALL implement 3 registered stages F, D/X, W plus sync fetch memory: instruction enters D when i_pc_rddata is valid, then X, then W.
REQ-011 SHALL decode ir[3:0] opcode, ir[4] immediate flag, rx=ir[7:5], ry=ir[10:8], imm8=ir[15:8], imm11=ir[15:5], both sign-extended to DATA_W.
REQ-012 SHALL support opcodes: 0 mv, 1 add, 2 sub, 3 cmp, 4 ld, 5 st, 6 mvhi, 7 nop, 8 j, 9 jz, 10 jn, 12 call; others are nop.
REQ-013 SHALL, for mv/add/sub/cmp, use imm8 as operand B when ir[4]=1, else ry.
REQ-014 SHALL compute add/sub/cmp modulo 2^DATA_W; n=result[DATA_W-1], z=(result==0); flags update only on add/sub/cmp in X.
REQ-015 SHALL compute mvhi as (imm8 << 8) | rx[7:0] before truncation to DATA_W.
REQ-016 SHALL issue ld/st in X: o_ldst_addr=ry, o_ldst_wrdata=rx, o_ldst_rd/o_ldst_wr asserted exactly one non-stalled cycle; ld writes i_ldst_rddata to rx in W.
REQ-017 SHALL resolve j/jz/jn/call in X: target = rx if ir[4]=0, else pc_X + 2*imm11; jz taken if o_z, jn taken if o_n.
REQ-018 SHALL, on taken branch, drive o_pc_addr=target combinationally that cycle, load pc<=target+2, and squash the next instruction entering X to NOP_IR (one bubble).
REQ-019 SHALL write pc_X+2 to r7 in W for call.
REQ-020 SHALL write register file at W clock edge; a D-stage read of the register being written SHALL return the new value (write-through).
REQ-021 SHALL, when FWD_EN=1, bypass W result to X rx/ry operands (incl. branch target, st data/addr) when W writes the same register.
REQ-022 SHALL, while i_stall=1, hold pc, all IRs, operands, flags, register file; o_ldst_rd/wr deasserted; o_pc_addr holds.
REQ-023 SHALL give branch redirect priority over normal fetch; stall priority over branch (redirect taken on first non-stalled cycle).
REQ-024 SHALL increment pc by 2 with wrap at 2^DATA_W.

Reset
REQ-030 SHALL, on reset, clear pc, r0..r7, o_n, o_z, o_ldst_rd, o_ldst_wr to 0 and load D/X/W IRs with NOP_IR.
REQ-031 SHALL treat reset as dominant over i_stall and any in-flight branch; first fetch address after reset is 0.

Structure
REQ-040 SHALL place opcode enum, field bit positions, NOP_IR default in package pipe_datapath_pkg.
REQ-041 SHALL instantiate one sub-module regfile_p (8xDATA_W, 2 read, 1 write, write-through, tb image port).

Verification
REQ-050 SHALL test: mvi r1,5; mvi r2,3; add r1,r2 (back-to-back) -> r1=8 with FWD_EN=1, n=0, z=0.
REQ-051 SHALL test: mvi r1,1; sub r1,1; jz +4 -> branch taken, exactly one NOP in X, pc continues at target.
REQ-052 SHALL test: st r3->[r4=0x20] then ld r5,[r4] -> o_ldst_wr then o_ldst_rd at 0x20, r5=r3.
REQ-053 SHALL test: call r6=0x40 from pc 0x10 -> r7=0x12, next fetch 0x40.
REQ-054 SHALL test: i_stall held 3 cycles mid-add sequence -> state frozen, final regs identical to unstalled run.
REQ-055 SHALL test: DATA_W=32, mvi r1,-1; add r1,1 -> r1=0, z=1; reset asserted mid-branch -> pc=0, regs cleared.
